hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for a 5-stage pipeline: operand forwarding, load-use and
// multi-cycle (MUL/DIV) interlocks, redirect flushes and a saturating stall counter.
module hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int SC_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic [1:0]        ResultSrcE,
    input  logic              PCSrc,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MdOpD,
    input  logic              MdStartE,
    input  logic              StallCntClr,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic              MdBusy,
    output logic [REG_AW-1:0] MdRd,
    output logic              MdWbValid,
    output logic              MdErr,
    output logic [SC_W-1:0]   StallCnt
);

    localparam int CNT_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MD_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [REG_AW-1:0] REG_X0   = {REG_AW{1'b0}};
    localparam logic [SC_W-1:0]   SC_MAX   = {SC_W{1'b1}};
    localparam logic [SC_W-1:0]   SC_ONE   = {{(SC_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REG_AW-1:0] md_rd_q, md_rd_d;
    logic              md_err_q, md_err_d;
    logic [SC_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic lw_stall_s;
    logic md_stall_s;
    logic stall_s;
    logic md_busy_s;
    logic md_wb_valid_s;

    // A write from M is newer than one from W, so M wins; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              we_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_w
    );
        if ((rs != REG_X0) && we_m && (rs == rd_m)) begin
            return 2'b10;
        end else if ((rs != REG_X0) && we_w && (rs == rd_w)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    function automatic logic reads_reg(
        input logic [REG_AW-1:0] rs1,
        input logic [REG_AW-1:0] rs2,
        input logic [REG_AW-1:0] rd
    );
        return ((rs1 != REG_X0) && (rs1 == rd)) || ((rs2 != REG_X0) && (rs2 == rd));
    endfunction

    // Forwarding, interlock and flush decode.
    always_comb begin
        ForwardAE  = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        ForwardBE  = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
        lw_stall_s = (ResultSrcE == 2'b01) && (RdE != REG_X0)
                     && ((Rs1D == RdE) || (Rs2D == RdE));
        md_stall_s = (md_busy_s && (MdOpD || reads_reg(Rs1D, Rs2D, md_rd_q)))
                     || (MdStartE && (MdOpD || reads_reg(Rs1D, Rs2D, RdE)));
        stall_s    = (lw_stall_s || md_stall_s) && !PCSrc;
        StallF     = stall_s;
        StallD     = stall_s;
        FlushD     = PCSrc;
        FlushE     = lw_stall_s || md_stall_s || PCSrc;
    end

    // Tracker state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            md_rd_q     <= REG_X0;
            md_err_q    <= 1'b0;
            stall_cnt_q <= {SC_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            md_rd_q     <= md_rd_d;
            md_err_q    <= md_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Tracker next state; a start while busy is dropped and flagged, redirects never cancel.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_rd_d  = md_rd_q;
        md_err_d = md_err_q || (MdStartE && md_busy_s);
        case (state_q)
            IDLE: begin
                if (MdStartE) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                    md_rd_d = RdE;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (md_wb_valid_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        if (StallCntClr) begin
            stall_cnt_d = {SC_W{1'b0}};
        end else if (stall_s && (stall_cnt_q != SC_MAX)) begin
            stall_cnt_d = stall_cnt_q + SC_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Tracker outputs; the pipeline's own W write has priority over the MD result.
    always_comb begin
        md_busy_s     = (state_q == BUSY);
        md_wb_valid_s = md_busy_s && (cnt_q == CNT_ZERO) && !RegWriteW;
        MdBusy        = md_busy_s;
        MdWbValid     = md_wb_valid_s;
        MdRd          = md_rd_q;
        MdErr         = md_err_q;
        StallCnt      = stall_cnt_q;
    end

endmodule
